interleaver_buffer_ctrl: RTL and testbench
==========================================

# interleaver_buffer_ctrl

Ping-pong block buffer and sequencer between the bit interleaver and the modulator. It captures each interleaved bit at its permuted index (0..NCBPS-1) into one of two NCBPS-bit banks. Completed blocks are released to the modulator in natural index order under a valid/ready handshake. While one bank drains, the other fills, so the interleaver only stalls when both banks are full.

## Interface
- NCBPS, 192: coded bits per block (bank depth)
- IDX_W, 9: index width; must satisfy 2^IDX_W > NCBPS
- BLK_CNT_W, 16: width of drained-block counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  interleaved bit valid (from interleaver valid output)
- in_data  in  1  interleaved bit
- in_index  in  IDX_W  permuted destination index j of in_data
- in_ready  out  1  buffer can accept a bit this cycle
- flush  in  1  discard the partially filled bank
- out_valid  out  1  out_data valid to modulator
- out_data  out  1  bit at current read index; 0 when out_valid=0
- out_ready  in  1  modulator accepts out_data
- out_first  out  1  out_valid and read index = 0
- out_last  out  1  out_valid and read index = NCBPS-1
- err_index  out  1  sticky: an accepted bit had in_index >= NCBPS
- blk_cnt  out  BLK_CNT_W  count of fully drained blocks, wraps

## Operation
- State: bank[0:1] storage (NCBPS bits each, not reset), full[1:0], wr_bank, rd_bank, wr_cnt and rd_cnt (0..NCBPS-1), err_index, blk_cnt.
- Write accept: in_valid & in_ready, where in_ready = !full[wr_bank].
  - On accept, bank[wr_bank][in_index] <= in_data if in_index < NCBPS.
  - Otherwise the write is dropped and err_index <= 1; wr_cnt still advances.
- Block complete: accept with wr_cnt = NCBPS-1. It sets full[wr_bank], sets wr_cnt <= 0 and toggles wr_bank.
- Duplicate indices are not detected. Completion is by count only; unwritten positions hold stale data.
- Read: out_valid = full[rd_bank]; out_data = bank[rd_bank][rd_cnt]. A transfer is out_valid & out_ready and advances rd_cnt.
- Drain complete: transfer at rd_cnt = NCBPS-1. It clears full[rd_bank], sets rd_cnt <= 0, toggles rd_bank and increments blk_cnt (wraps at 2^BLK_CNT_W).
- Simultaneous complete and drain: completing a fill on one bank and finishing a drain on the other in the same cycle are independent. Both flag updates apply.
- Flush:
  - Sets wr_cnt <= 0 and keeps wr_bank; the partial data is abandoned.
  - Full banks, rd_cnt and read-side state are unaffected.
  - An accept in the same cycle as flush is discarded: no bank write, no count, no completion, no err_index.
- Out-of-range input is never committed to storage.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_first=0, out_last=0, err_index=0, blk_cnt=0.
  - wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full=2'b00.
- in_ready, out_valid, out_first and out_last are combinational from registered state only. in_ready has no combinational path from out_ready.
- Latency: NCBPS-th accept at edge N gives out_valid=1 in the cycle after edge N. The first bit out is at index 0.
- Continuous rates: with out_ready=1 and in_valid=1 both sides sustain 1 bit/cycle, and in_ready never drops.
- Backpressure: once both banks are full, in_ready=0. It returns to 1 the cycle after the drain completes.
- Reset mid-block: all flags and counters return to reset values next edge. No partial block is emitted.

## Structure
- Package interleaver_pkg:
  - NCBPS, IDX_W and BLK_CNT_W defaults.
  - localparam CNT_W = $clog2(NCBPS).
  - typedef for index and count types.
- Sub-module interleaver_bank, instantiated twice: NCBPS-bit register, one write port (en, addr, data), one combinational read port (addr). Address range checking is done in the controller.
- The controller holds the counters, bank pointers, full flags, flush handling and status outputs.

## Test plan
- Ordered permutation (k=0..191, j=12*(k%16)+k/16, e.g. k=1→j=12, k=16→j=1), in_data=k[0], out_ready=1 → 192 out bits with out_data[j] = (k of j)[0], out_first at j=0, out_last at j=191, blk_cnt=1.
- Four back-to-back blocks with in_valid and out_ready held high → in_ready never deasserts, 768 transfers, blk_cnt=4.
- out_ready=0 while streaming → in_ready falls after exactly 384 accepts. Raise out_ready → in_ready=1 one cycle after the 192nd output.
- Accept 50 bits, then flush with in_valid=1 → that bit is discarded. The next 192 accepts form a complete block, and no output appears before them.
- One accepted bit with in_index=200 → err_index=1 and stays set. The block still completes after 192 accepts, and the position left unwritten holds its prior (stale) value.
- Reset asserted mid-drain (rd_cnt=100) with the second bank full → next cycle out_valid=0, in_ready=1, blk_cnt=0.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared defaults and types for the interleaver block buffer.
package interleaver_pkg;

  localparam int unsigned NCBPS_DEF     = 192;
  localparam int unsigned IDX_W_DEF     = 9;
  localparam int unsigned BLK_CNT_W_DEF = 16;

  localparam int unsigned CNT_W = $clog2(NCBPS_DEF);

  typedef logic [IDX_W_DEF-1:0] idx_t;
  typedef logic [CNT_W-1:0]     cnt_t;

endpackage

// File: rtl/interleaver_bank.sv
// One NCBPS-bit storage bank: single write port, combinational read port.
module interleaver_bank
  import interleaver_pkg::*;
#(
  parameter int unsigned Depth = NCBPS_DEF,
  parameter int unsigned AddrW = CNT_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic             wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic             rd_data
);

  logic [Depth-1:0] mem_q;

  // Storage is deliberately not reset; addresses are range-checked upstream.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read of the addressed bit.
  always_comb begin
    rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/interleaver_buffer_ctrl.sv
// Ping-pong block buffer between the bit interleaver and the modulator.
module interleaver_buffer_ctrl
  import interleaver_pkg::*;
#(
  parameter int unsigned NCBPS     = NCBPS_DEF,
  parameter int unsigned IDX_W     = IDX_W_DEF,
  parameter int unsigned BLK_CNT_W = BLK_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_data,
  input  logic [IDX_W-1:0]     in_index,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  output logic                 out_data,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 err_index,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  localparam int unsigned CntW = $clog2(NCBPS);
  localparam logic [CntW-1:0] LastCnt = CntW'(NCBPS - 1);

  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [CntW-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]      rd_cnt_q, rd_cnt_d;
  logic                 err_q, err_d;
  logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  logic       accept, in_range, wr_done, xfer, rd_done;
  logic [1:0] bank_we, bank_rd;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    interleaver_bank #(
      .Depth (NCBPS),
      .AddrW (CntW)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we[gi]),
      .wr_addr (in_index[CntW-1:0]),
      .wr_data (in_data),
      .rd_addr (rd_cnt_q),
      .rd_data (bank_rd[gi])
    );
  end

  // Handshake decode and status outputs, all from registered state.
  always_comb begin
    in_ready  = ~full_q[wr_bank_q];
    // A flush cycle swallows any concurrent input bit entirely.
    accept    = in_valid & in_ready & ~flush;
    in_range  = in_index < IDX_W'(NCBPS);
    wr_done   = accept & (wr_cnt_q == LastCnt);
    bank_we   = '0;
    bank_we[wr_bank_q] = accept & in_range;
    out_valid = full_q[rd_bank_q];
    out_data  = out_valid & bank_rd[rd_bank_q];
    out_first = out_valid & (rd_cnt_q == '0);
    out_last  = out_valid & (rd_cnt_q == LastCnt);
    xfer      = out_valid & out_ready;
    rd_done   = xfer & (rd_cnt_q == LastCnt);
    err_index = err_q;
    blk_cnt   = blk_cnt_q;
  end

  // Next-state for fill and drain sides; they touch different banks' flags.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_d     = err_q;
    blk_cnt_d = blk_cnt_q;

    if (flush) begin
      wr_cnt_d = '0;
    end else if (accept) begin
      if (!in_range) begin
        err_d = 1'b1;
      end
      if (wr_done) begin
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (xfer) begin
      if (rd_done) begin
        rd_cnt_d          = '0;
        rd_bank_d         = ~rd_bank_q;
        full_d[rd_bank_q] = 1'b0;
        blk_cnt_d         = blk_cnt_q + 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_q     <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_interleaver_buffer_ctrl.sv
// Directed self-checking bench for interleaver_buffer_ctrl.
module tb_interleaver_buffer_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_data;
  logic [8:0]  in_index;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_data;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic        err_index;
  logic [15:0] blk_cnt;

  int n_checks;
  int n_fail;

  interleaver_buffer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_index  (in_index),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .err_index (err_index),
    .blk_cnt   (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    in_index  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic bit pat_b2b(int k);
    return 1'(((k / 3) ^ (k / 192)) & 1);
  endfunction

  function automatic bit pat_bp(int k);
    return 1'(((k % 5) == 0) ? 1 : 0) ^ 1'((k / 192) & 1);
  endfunction

  task automatic test_reset;
    do_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_data got=%b exp=0", out_data); end
    n_checks++; if (out_first !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_first got=%b exp=0", out_first); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_checks++; if (err_index !== 1'b0) begin n_fail++;
      $display("FAIL reset_err_index got=%b exp=0", err_index); end
    n_checks++; if (blk_cnt !== 16'd0) begin n_fail++;
      $display("FAIL reset_blk_cnt got=%0d exp=0", blk_cnt); end
  endtask

  task automatic test_permutation;
    bit exp_bits [192];
    int j;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 192; k++) begin
      j = 12 * (k % 16) + k / 16;
      exp_bits[j] = 1'(k & 1);
      in_valid = 1'b1;
      in_index = 9'(j);
      in_data  = 1'(k & 1);
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
        $display("FAIL perm_fill k=%0d in_ready=%b out_valid=%b exp 1/0", k, in_ready, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 192; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_bits[i] || out_first !== (i == 0)
          || out_last !== (i == 191)) begin
        n_fail++;
        $display("FAIL perm_out i=%0d v/d/f/l=%b%b%b%b exp=1%b%b%b", i, out_valid, out_data,
                 out_first, out_last, exp_bits[i], i == 0, i == 191);
      end
      tick();
    end
    n_checks++; if (blk_cnt !== 16'd1 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL perm_done blk_cnt=%0d out_valid=%b exp 1/0", blk_cnt, out_valid); end
  endtask

  task automatic test_back_to_back;
    int  k, nout, cyc;
    bit  acc;
    do_reset();
    out_ready = 1'b1;
    k = 0; nout = 0; cyc = 0;
    while ((k < 768 || nout < 768) && cyc < 1200) begin
      if (k < 768) begin
        in_valid = 1'b1;
        in_index = 9'(k % 192);
        in_data  = pat_b2b(k);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
          $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        n_checks++; if (out_data !== pat_b2b(nout)) begin n_fail++;
          $display("FAIL b2b_data n=%0d got=%b exp=%b", nout, out_data, pat_b2b(nout)); end
        nout++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++; if (nout != 768) begin n_fail++;
      $display("FAIL b2b_transfers got=%0d exp=768", nout); end
    n_checks++; if (blk_cnt !== 16'd4) begin n_fail++;
      $display("FAIL b2b_blk_cnt got=%0d exp=4", blk_cnt); end
  endtask

  task automatic test_backpressure;
    int acc, nout, cyc;
    do_reset();
    out_ready = 1'b0;
    acc = 0; cyc = 0;
    in_valid = 1'b1;
    while (in_ready === 1'b1 && cyc < 600) begin
      in_index = 9'(acc % 192);
      in_data  = pat_bp(acc);
      tick();
      acc++;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++; if (acc != 384) begin n_fail++;
      $display("FAIL bp_accepts got=%0d exp=384", acc); end
    out_ready = 1'b1;
    nout = 0; cyc = 0;
    while (nout < 192 && cyc < 400) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_hold n=%0d in_ready=%b exp=0", nout, in_ready); end
      if (out_valid === 1'b1) begin
        n_checks++; if (out_data !== pat_bp(nout)) begin n_fail++;
          $display("FAIL bp_data n=%0d got=%b exp=%b", nout, out_data, pat_bp(nout)); end
        nout++;
      end
      tick();
      cyc++;
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_release in_ready=%b exp=1", in_ready); end
    cyc = 0;
    while (nout < 384 && cyc < 400) begin
      if (out_valid === 1'b1) begin
        n_checks++; if (out_data !== pat_bp(nout)) begin n_fail++;
          $display("FAIL bp_data2 n=%0d got=%b exp=%b", nout, out_data, pat_bp(nout)); end
        nout++;
      end
      tick();
      cyc++;
    end
    n_checks++; if (blk_cnt !== 16'd2 || nout != 384) begin n_fail++;
      $display("FAIL bp_end blk_cnt=%0d nout=%0d exp 2/384", blk_cnt, nout); end
  endtask

  task automatic test_flush;
    int nout, cyc;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      in_valid = 1'b1;
      in_index = 9'(k);
      in_data  = 1'b1;
      tick();
    end
    flush    = 1'b1;
    in_index = 9'd50;
    in_data  = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 192; k++) begin
      in_index = 9'(k);
      in_data  = 1'((k % 4) == 1);
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
        $display("FAIL flush_early k=%0d out_valid=%b in_ready=%b exp 0/1", k, out_valid,
                 in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    nout = 0; cyc = 0;
    while (nout < 192 && cyc < 300) begin
      if (out_valid === 1'b1) begin
        n_checks++; if (out_data !== 1'((nout % 4) == 1)) begin n_fail++;
          $display("FAIL flush_data n=%0d got=%b exp=%b", nout, out_data, (nout % 4) == 1); end
        nout++;
      end
      tick();
      cyc++;
    end
    n_checks++; if (blk_cnt !== 16'd1 || nout != 192) begin n_fail++;
      $display("FAIL flush_end blk_cnt=%0d nout=%0d exp 1/192", blk_cnt, nout); end
  endtask

  task automatic test_err_index;
    int s_idx [576];
    bit s_dat [576];
    bit e_dat [576];
    int k, nout, cyc;
    bit acc, bad;
    for (int i = 0; i < 192; i++) begin
      s_idx[i] = i;            s_dat[i] = 1'(i % 2);     e_dat[i] = 1'(i % 2);
      s_idx[192 + i] = i;      s_dat[192 + i] = 1'b0;    e_dat[192 + i] = 1'b0;
      s_idx[384 + i] = (i == 7) ? 200 : i;
      s_dat[384 + i] = (i == 7) ? 1'b0 : 1'((i % 3) == 0);
      // Position 7 is never written in the third block: it keeps block 1's bit.
      e_dat[384 + i] = (i == 7) ? 1'b1 : 1'((i % 3) == 0);
    end
    do_reset();
    out_ready = 1'b1;
    k = 0; nout = 0; cyc = 0;
    while ((k < 576 || nout < 576) && cyc < 1500) begin
      if (k < 576) begin
        in_valid = 1'b1;
        in_index = 9'(s_idx[k]);
        in_data  = s_dat[k];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        n_checks++; if (out_data !== e_dat[nout]) begin n_fail++;
          $display("FAIL err_data n=%0d got=%b exp=%b", nout, out_data, e_dat[nout]); end
        nout++;
      end
      acc = in_valid && in_ready;
      bad = acc && (k == 391);
      if (bad) begin
        n_checks++; if (err_index !== 1'b0) begin n_fail++;
          $display("FAIL err_before got=%b exp=0", err_index); end
      end
      tick();
      if (bad) begin
        n_checks++; if (err_index !== 1'b1) begin n_fail++;
          $display("FAIL err_set got=%b exp=1", err_index); end
      end
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++; if (err_index !== 1'b1 || blk_cnt !== 16'd3 || nout != 576) begin n_fail++;
      $display("FAIL err_end err=%b blk_cnt=%0d nout=%0d exp 1/3/576", err_index, blk_cnt, nout);
    end
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 384; k++) begin
      in_index = 9'(k % 192);
      in_data  = 1'(k & 1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL rmd_pre out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== 16'd0 || out_data !== 1'b0) begin
      n_fail++;
      $display("FAIL rmd_post out_valid=%b in_ready=%b blk_cnt=%0d out_data=%b exp 0/1/0/0",
               out_valid, in_ready, blk_cnt, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
        $display("FAIL rmd_idle i=%0d out_valid=%b exp=0", i, out_valid); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    test_reset();
    test_permutation();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_err_index();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
